mult_div_unit: RTL and testbench

MULT_DIV_UNIT -- requirements
Module: mult_div_unit

---
 rtl/mult_div_unit_pkg.sv | 27 ++
 rtl/mult_div_unit_step.sv | 32 +++
 rtl/mult_div_unit.sv | 130 +++++++++++++
 tb/tb_mult_div_unit.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_div_unit_pkg.sv
// rtl/mult_div_unit_pkg.sv - shared op/state encodings and helpers for the mult/div unit
package mult_div_unit_pkg;

    localparam int unsigned MD_WIDTH = 32;
    localparam logic [5:0]  MD_LAST_ITER = 6'd31;

    // Operation encoding, shared with the ALU control decode
    typedef enum logic [1:0] {
        OP_MULT  = 2'b00,
        OP_MULTU = 2'b01,
        OP_DIV   = 2'b10,
        OP_DIVU  = 2'b11
    } md_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_CALC = 2'b01,
        ST_FIX  = 2'b10,
        ST_DONE = 2'b11
    } md_state_e;

    // Two's-complement magnitude when neg is set, raw value otherwise
    function automatic logic [MD_WIDTH-1:0] mag(input logic [MD_WIDTH-1:0] v, input logic neg);
        return neg ? (~v + 1'b1) : v;
    endfunction

endpackage

// File: rtl/mult_div_unit_step.sv
// rtl/mult_div_unit_step.sv - one shift-add / restoring shift-subtract iteration
module md_step
    import mult_div_unit_pkg::*;
(
    input  logic                    is_div,
    input  logic [2*MD_WIDTH-1:0]   acc,
    input  logic [MD_WIDTH-1:0]     operand,
    output logic [2*MD_WIDTH-1:0]   acc_next
);

    logic [MD_WIDTH:0]   sum;
    logic [MD_WIDTH:0]   part_rem;
    logic [MD_WIDTH+1:0] diff;

    // Multiply: acc = {partial product, multiplier}; add multiplicand on LSB then shift right with carry.
    // Divide: acc = {remainder, dividend/quotient}; shift left, trial-subtract divisor, restore if negative.
    always_comb begin
        sum      = {1'b0, acc[2*MD_WIDTH-1:MD_WIDTH]} + (acc[0] ? {1'b0, operand} : {(MD_WIDTH+1){1'b0}});
        part_rem = {acc[2*MD_WIDTH-1:MD_WIDTH], acc[MD_WIDTH-1]};
        diff     = {1'b0, part_rem} - {2'b00, operand};
        if (is_div) begin
            if (diff[MD_WIDTH+1]) begin
                acc_next = {part_rem[MD_WIDTH-1:0], acc[MD_WIDTH-2:0], 1'b0};
            end else begin
                acc_next = {diff[MD_WIDTH-1:0], acc[MD_WIDTH-2:0], 1'b1};
            end
        end else begin
            acc_next = {sum, acc[MD_WIDTH-1:1]};
        end
    end

endmodule

// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
module mult_div_unit
    import mult_div_unit_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] A,
    input  logic [31:0] B,
    input  logic        write_hi,
    input  logic        write_lo,
    output logic        busy,
    output logic        done,
    output logic        div_by_zero,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    md_state_e   state;
    md_op_e      op_q;
    logic [63:0] acc;
    logic [31:0] operand;
    logic        neg_res;
    logic        neg_rem;
    logic [5:0]  iter;

    logic        signed_op;
    logic        sign_a;
    logic        sign_b;
    logic [31:0] mag_a;
    logic [31:0] mag_b;
    logic        div_q;
    logic [63:0] step_acc;
    logic [31:0] fix_hi;
    logic [31:0] fix_lo;

    // Operand conditioning for the launch cycle
    always_comb begin
        signed_op = ~op[0];
        sign_a    = signed_op & A[31];
        sign_b    = signed_op & B[31];
        mag_a     = mag(A, sign_a);
        mag_b     = mag(B, sign_b);
        div_q     = (op_q == OP_DIV) || (op_q == OP_DIVU);
    end

    md_step u_step (
        .is_div   (div_q),
        .acc      (acc),
        .operand  (operand),
        .acc_next (step_acc)
    );

    // Sign correction of the raw magnitude result
    always_comb begin
        fix_hi = acc[63:32];
        fix_lo = acc[31:0];
        case (op_q)
            OP_MULT, OP_MULTU: begin
                {fix_hi, fix_lo} = neg_res ? (~acc + 64'd1) : acc;
            end
            default: begin
                fix_lo = neg_res ? (~acc[31:0] + 32'd1) : acc[31:0];
                fix_hi = neg_rem ? (~acc[63:32] + 32'd1) : acc[63:32];
            end
        endcase
    end

    // Control FSM, iteration counter and HI/LO registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= ST_IDLE;
            op_q        <= OP_MULT;
            acc         <= 64'd0;
            operand     <= 32'd0;
            neg_res     <= 1'b0;
            neg_rem     <= 1'b0;
            iter        <= 6'd0;
            busy        <= 1'b0;
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            HI          <= 32'd0;
            LO          <= 32'd0;
        end else begin
            done        <= 1'b0;
            div_by_zero <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        op_q    <= md_op_e'(op);
                        neg_res <= sign_a ^ sign_b;
                        neg_rem <= sign_a;
                        iter    <= 6'd0;
                        busy    <= 1'b1;
                        if (op[1] && (B == 32'd0)) begin
                            state       <= ST_DONE;
                            done        <= 1'b1;
                            div_by_zero <= 1'b1;
                        end else begin
                            state   <= ST_CALC;
                            operand <= op[1] ? mag_b : mag_a;
                            acc     <= {32'd0, (op[1] ? mag_a : mag_b)};
                        end
                    end else begin
                        if (write_hi) HI <= A;
                        if (write_lo) LO <= A;
                    end
                end
                ST_CALC: begin
                    acc  <= step_acc;
                    iter <= iter + 6'd1;
                    if (iter == MD_LAST_ITER) state <= ST_FIX;
                end
                ST_FIX: begin
                    HI    <= fix_hi;
                    LO    <= fix_lo;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb/tb_mult_div_unit.sv - scoreboard bench for mult_div_unit
module tb_mult_div_unit;
    import mult_div_unit_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [1:0]  op;
    logic [31:0] A;
    logic [31:0] B;
    logic        write_hi;
    logic        write_lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;
    logic [31:0] HI;
    logic [31:0] LO;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dbz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    int          done_count = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mult_div_unit dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .op          (op),
        .A           (A),
        .B           (B),
        .write_hi    (write_hi),
        .write_lo    (write_lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero),
        .HI          (HI),
        .LO          (LO)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, output exp_t e);
        logic [63:0] p;
        logic [31:0] q;
        logic [31:0] r;
        e.dbz = 1'b0;
        e.cyc = 0;
        case (o)
            2'b00: begin
                p = {{32{a[31]}}, a} * {{32{b[31]}}, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            2'b01: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32];
                m_lo = p[31:0];
            end
            default: begin
                if (b == 32'd0) begin
                    e.dbz = 1'b1;
                end else begin
                    if (o == 2'b10) begin
                        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                            q = a;
                            r = 32'd0;
                        end else begin
                            q = 32'($signed(a) / $signed(b));
                            r = 32'($signed(a) % $signed(b));
                        end
                    end else begin
                        q = a / b;
                        r = a % b;
                    end
                    m_hi = r;
                    m_lo = q;
                end
            end
        endcase
        e.hi = m_hi;
        e.lo = m_lo;
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the first idle cycle
    task automatic do_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit disturb);
        exp_t e;
        int   lat;
        int   d0;
        model(o, a, b, e);
        lat   = e.dbz ? 1 : 34;
        e.cyc = cyc + lat;
        sb.push_back(e);
        d0    = done_count;
        start = 1'b1;
        op    = o;
        A     = a;
        B     = b;
        if (disturb) write_hi = 1'b1;
        @(posedge clk);
        for (int k = 1; k <= lat + 1; k++) begin
            @(negedge clk);
            check("busy", busy, (k <= lat));
            if (k == 1) begin
                start    = 1'b0;
                write_hi = 1'b0;
                A        = $urandom;
                B        = $urandom;
                op       = 2'($urandom);
            end
            if (disturb) begin
                if (k == 10) begin
                    start = 1'b1;
                    op    = OP_DIV;
                    A     = 32'h0000_0009;
                    B     = 32'd0;
                end
                if (k == 11) start = 1'b0;
                if (k == 20) begin
                    write_lo = 1'b1;
                    A        = 32'h0000_DEAD;
                end
                if (k == 21) write_lo = 1'b0;
            end
        end
        check("done_seen", done_count - d0, 1);
        check("hi_hold", HI, m_hi);
        check("lo_hold", LO, m_lo);
    endtask

    task automatic write_regs(input logic [31:0] hv, input logic [31:0] lv);
        write_hi = 1'b1;
        A        = hv;
        @(negedge clk);
        write_hi = 1'b0;
        write_lo = 1'b1;
        A        = lv;
        @(negedge clk);
        write_lo = 1'b0;
        m_hi     = hv;
        m_lo     = lv;
        check("mthi", HI, hv);
        check("mtlo", LO, lv);
    endtask

    // Result monitor: every done pulse pops one expected result
    initial begin
        forever begin
            @(negedge clk);
            if (reset === 1'b1 && done === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_done", done, 0);
                end else begin
                    mon_e = sb.pop_front();
                    check("HI", HI, mon_e.hi);
                    check("LO", LO, mon_e.lo);
                    check("div_by_zero", div_by_zero, mon_e.dbz);
                    check("done_cycle", cyc, mon_e.cyc);
                end
                done_count++;
            end
        end
    end

    initial begin
        int d0;
        reset    = 1'b0;
        start    = 1'b0;
        op       = 2'b00;
        A        = 32'd0;
        B        = 32'd0;
        write_hi = 1'b0;
        write_lo = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_hi", HI, 0);
        check("rst_lo", LO, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_dbz", div_by_zero, 0);
        reset = 1'b1;
        @(negedge clk);

        do_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
        do_op(OP_MULT,  32'hFFFF_FFFD, 32'd5,         1'b0);
        do_op(OP_MULT,  32'h8000_0000, 32'h8000_0000, 1'b0);
        do_op(OP_DIV,   32'hFFFF_FFF9, 32'd2,         1'b0);
        do_op(OP_DIVU,  32'd100,       32'd7,         1'b0);
        do_op(OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        do_op(OP_DIV,   32'd7,         32'hFFFF_FFFE, 1'b0);
        write_regs(32'h11, 32'h22);
        do_op(OP_DIVU,  32'd5,         32'd0,         1'b0);
        do_op(OP_DIV,   32'h8000_0001, 32'd0,         1'b0);
        do_op(OP_MULTU, 32'd3,         32'd4,         1'b1);
        for (int i = 0; i < 8; i++) begin
            do_op(2'($urandom), $urandom, $urandom, 1'b0);
        end

        write_regs(32'hAAAA_5555, 32'h0000_1234);
        start = 1'b1;
        op    = OP_MULT;
        A     = 32'd7;
        B     = 32'd9;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        reset = 1'b0;
        #1;
        check("abort_hi", HI, 0);
        check("abort_lo", LO, 0);
        check("abort_busy", busy, 0);
        check("abort_done", done, 0);
        m_hi = 32'd0;
        m_lo = 32'd0;
        d0   = done_count;
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        check("no_done_after_abort", done_count - d0, 0);
        check("idle_after_abort", busy, 0);

        do_op(OP_DIVU, 32'hFFFF_FFFF, 32'd16, 1'b0);
        check("scoreboard_empty", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
